ps2_mouse_controller: RTL

PS2_MOUSE_CONTROLLER -- requirements
Module: ps2_mouse_controller

---
 rtl/ps2_mouse_pkg.sv | 30 +++
 rtl/ps2_mouse_axis.sv | 40 ++++
 rtl/ps2_mouse_controller.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse controller: FSM states, protocol bytes,
// default screen limits and the cursor centre.
package ps2_mouse_pkg;

  typedef enum logic [3:0] {
    StSendRst,
    StWaitAckRst,
    StWaitBat,
    StWaitId,
    StSendEn,
    StWaitAckEn,
    StPktB1,
    StPktB2,
    StPktB3,
    StUpdate,
    StError
  } state_e;

  localparam logic [7:0] CmdReset  = 8'hFF;
  localparam logic [7:0] CmdEnable = 8'hF4;
  localparam logic [7:0] RspAck    = 8'hFA;
  localparam logic [7:0] RspBatOk  = 8'hAA;
  localparam logic [7:0] RspId     = 8'h00;

  localparam int unsigned XMaxDefault = 319;
  localparam int unsigned YMaxDefault = 239;
  localparam logic [8:0]  XCentre     = 9'd160;
  localparam logic [7:0]  YCentre     = 8'd120;

endpackage

// File: rtl/ps2_mouse_axis.sv
// Combinational per-axis cursor update: sign-extend and shift the delta, add or subtract it,
// then clamp the result to 0..max.
module ps2_mouse_axis #(
  parameter int unsigned SHIFT  = 1,
  parameter bit          Invert = 1'b0
) (
  input  logic [8:0] pos_i,
  input  logic       sign_i,
  input  logic [7:0] byte_i,
  input  logic       overflow_i,
  input  logic [8:0] max_i,
  output logic [8:0] pos_o
);

  logic signed [8:0]  raw;
  logic signed [8:0]  delta;
  logic signed [10:0] delta_ext;
  logic signed [10:0] pos_ext;
  logic signed [10:0] max_ext;
  logic signed [10:0] sum;

  assign raw       = {sign_i, byte_i};
  assign delta     = overflow_i ? 9'sd0 : (raw >>> SHIFT);
  assign delta_ext = {{2{delta[8]}}, delta};
  assign pos_ext   = {2'b00, pos_i};
  assign max_ext   = {2'b00, max_i};
  // The Y axis subtracts so that device "up" moves the cursor towards row 0.
  assign sum       = Invert ? (pos_ext - delta_ext) : (pos_ext + delta_ext);

  always_comb begin
    if (sum[10]) begin
      pos_o = 9'd0;
    end else if (sum > max_ext) begin
      pos_o = max_i;
    end else begin
      pos_o = sum[8:0];
    end
  end

endmodule

// File: rtl/ps2_mouse_controller.sv
// PS/2 mouse controller: runs the reset/enable init handshake with retries, then decodes
// 3-byte stream-mode packets into a clamped cursor position and button state.
module ps2_mouse_controller
  import ps2_mouse_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES     = 50000000,
  parameter int unsigned PKT_TIMEOUT_CYCLES = 2500000,
  parameter int unsigned MAX_RETRIES        = 3,
  parameter int unsigned SHIFT              = 1,
  parameter int unsigned X_MAX              = XMaxDefault,
  parameter int unsigned Y_MAX              = YMaxDefault
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] rx_data_i,
  input  logic       rx_data_en_i,
  input  logic       cmd_was_sent_i,
  input  logic       cmd_error_i,
  output logic [7:0] cmd_out_o,
  output logic       cmd_send_o,
  output logic [8:0] x_pos_o,
  output logic [7:0] y_pos_o,
  output logic       left_btn_o,
  output logic       right_btn_o,
  output logic       packet_valid_o,
  output logic       ready_o,
  output logic       init_error_o
);

  state_e      state_q, state_d;
  logic [7:0]  retry_q, retry_d;
  logic [31:0] timer_q, timer_d;
  logic [7:0]  b1_q, b1_d;
  logic [7:0]  dx_q, dx_d;
  logic [7:0]  dy_q, dy_d;
  logic [8:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic        left_q, left_d;
  logic        right_q, right_d;
  logic [7:0]  cmd_out_q, cmd_out_d;
  logic        cmd_send_q, cmd_send_d;

  logic [8:0]  x_next;
  logic [8:0]  y_next;
  logic        retry;
  logic        init_timeout;
  logic        pkt_timeout;
  logic        unused_bits;

  ps2_mouse_axis #(
    .SHIFT  (SHIFT),
    .Invert (1'b0)
  ) u_axis_x (
    .pos_i      (x_q),
    .sign_i     (b1_q[4]),
    .byte_i     (dx_q),
    .overflow_i (b1_q[6]),
    .max_i      (9'(X_MAX)),
    .pos_o      (x_next)
  );

  ps2_mouse_axis #(
    .SHIFT  (SHIFT),
    .Invert (1'b1)
  ) u_axis_y (
    .pos_i      ({1'b0, y_q}),
    .sign_i     (b1_q[5]),
    .byte_i     (dy_q),
    .overflow_i (b1_q[7]),
    .max_i      (9'(Y_MAX)),
    .pos_o      (y_next)
  );

  assign unused_bits  = ^{b1_q[2], y_next[8]};
  assign init_timeout = (timer_q == TIMEOUT_CYCLES - 1);
  assign pkt_timeout  = (timer_q == PKT_TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    b1_d    = b1_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    x_d     = x_q;
    y_d     = y_q;
    left_d  = left_q;
    right_d = right_q;
    retry   = 1'b0;

    unique case (state_q)
      StSendRst: begin
        if (cmd_was_sent_i) state_d = StWaitAckRst;
        else if (cmd_error_i) retry = 1'b1;
      end
      StWaitAckRst: begin
        if (rx_data_en_i) begin
          if (rx_data_i == RspAck) state_d = StWaitBat;
          else retry = 1'b1;
        end else if (cmd_error_i || init_timeout) begin
          retry = 1'b1;
        end
      end
      StWaitBat: begin
        if (rx_data_en_i) begin
          if (rx_data_i == RspBatOk) state_d = StWaitId;
          else retry = 1'b1;
        end else if (cmd_error_i || init_timeout) begin
          retry = 1'b1;
        end
      end
      StWaitId: begin
        if (rx_data_en_i) begin
          if (rx_data_i == RspId) state_d = StSendEn;
          else retry = 1'b1;
        end else if (cmd_error_i || init_timeout) begin
          retry = 1'b1;
        end
      end
      StSendEn: begin
        if (cmd_was_sent_i) state_d = StWaitAckEn;
        else if (cmd_error_i) retry = 1'b1;
      end
      StWaitAckEn: begin
        if (rx_data_en_i) begin
          if (rx_data_i == RspAck) state_d = StPktB1;
          else retry = 1'b1;
        end else if (cmd_error_i || init_timeout) begin
          retry = 1'b1;
        end
      end
      StPktB1: begin
        // Bit 3 is always set in a header byte; anything else is a misaligned stream.
        if (rx_data_en_i && rx_data_i[3]) begin
          b1_d    = rx_data_i;
          state_d = StPktB2;
        end
      end
      StPktB2: begin
        if (rx_data_en_i) begin
          dx_d    = rx_data_i;
          state_d = StPktB3;
        end else if (pkt_timeout) begin
          state_d = StPktB1;
        end
      end
      StPktB3: begin
        if (rx_data_en_i) begin
          dy_d    = rx_data_i;
          state_d = StUpdate;
        end else if (pkt_timeout) begin
          state_d = StPktB1;
        end
      end
      StUpdate: begin
        x_d     = x_next;
        y_d     = y_next[7:0];
        left_d  = b1_q[0];
        right_d = b1_q[1];
        state_d = StPktB1;
      end
      StError: begin
        state_d = StError;
      end
      default: begin
        state_d = StSendRst;
      end
    endcase

    if (retry) begin
      if (retry_q == 8'(MAX_RETRIES)) begin
        state_d = StError;
      end else begin
        retry_d = retry_q + 8'd1;
        state_d = StSendRst;
      end
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q) timer_d = '0;
    else if (timer_q != '1) timer_d = timer_q + 32'd1;

    // Drop the request for a cycle after a handshake pulse so a resend starts afresh.
    cmd_send_d = ((state_d == StSendRst) || (state_d == StSendEn)) &&
                 !cmd_was_sent_i && !cmd_error_i;

    cmd_out_d = cmd_out_q;
    if (state_d == StSendRst) cmd_out_d = CmdReset;
    else if (state_d == StSendEn) cmd_out_d = CmdEnable;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StSendRst;
      retry_q    <= '0;
      timer_q    <= '0;
      b1_q       <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      x_q        <= XCentre;
      y_q        <= YCentre;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      cmd_out_q  <= 8'h00;
      cmd_send_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      b1_q       <= b1_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      x_q        <= x_d;
      y_q        <= y_d;
      left_q     <= left_d;
      right_q    <= right_d;
      cmd_out_q  <= cmd_out_d;
      cmd_send_q <= cmd_send_d;
    end
  end

  assign cmd_out_o      = cmd_out_q;
  assign cmd_send_o     = cmd_send_q;
  assign x_pos_o        = x_q;
  assign y_pos_o        = y_q;
  assign left_btn_o     = left_q;
  assign right_btn_o    = right_q;
  assign packet_valid_o = (state_q == StUpdate);
  assign ready_o        = (state_q == StPktB1) || (state_q == StPktB2) ||
                          (state_q == StPktB3) || (state_q == StUpdate);
  assign init_error_o   = (state_q == StError);

endmodule
